sdram_burst_sequencer: RTL and testbench
========================================

// Module: sdram_burst_sequencer
// PURPOSE
//  Multi-channel successor of the single-channel SDRAM write/read sequencer.
//  - Arbitrates NCH requesters, each able to ask for a write or a read burst over an address window.
//  - Drives the SDRAM core's start_wr/start_rd and address-window handshake.
//  - Manages the double-buffer (ping-pong) bank bit and the FIFO clear.
//  - Adds a timeout watchdog and window-validity checking.
//  - Sits between the acquisition/readout front-ends and the SDRAM core.
// PARAMETERS
//  ADDR_W   16      address width of begin/end windows
//  NCH      2       number of requesting channels (1..8)
//  TIMEOUT  65535   max cycles allowed in either flag wait state before err
//  SYNC     2       synchroniser depth for req_*/flag_* inputs (>=2)
// PORTS
//  clk            in   1            system clock
//  RST            in   1            async reset, active-high
//  req_wr         in   NCH          level write request per channel (async domain)
//  req_rd         in   NCH          level read request per channel (async domain)
//  wr_begin_in    in   NCH*ADDR_W   per-channel write window start; ch i at [i*ADDR_W +: ADDR_W]
//  wr_end_in      in   NCH*ADDR_W   per-channel write window end, inclusive
//  rd_begin_in    in   NCH*ADDR_W   per-channel read window start
//  rd_end_in      in   NCH*ADDR_W   per-channel read window end, inclusive
//  flag_wr        in   1            SDRAM core write-busy flag
//  flag_rd        in   1            SDRAM core read-busy flag
//  err_clr        in   1            synchronous clear of sticky err
//  start_wr       out  1            write burst command to core
//  start_rd       out  1            read burst command to core
//  addr_begin     out  ADDR_W       latched window start of granted op
//  addr_end       out  ADDR_W       latched window end of granted op
//  grant          out  NCH          one-hot owner of current op, 0 when idle
//  done           out  NCH          per-channel completion, held until that req drops
//  bank           out  1            ping-pong bank: writes target bank, reads target ~bank
//  clr            out  1            FIFO clear, high except during a write op
//  err            out  1            sticky error
//  err_code       out  2            1 = bad window, 2 = timeout, 3 = wr&rd both set; 0 = none
// BEHAVIOUR
//  Reset: start_wr=start_rd=0, addr_*=0, grant=0, done=0, bank=0, clr=1, err=0, err_code=0,
//   rr pointer=0, state=IDLE, synchronisers=0.
//  Inputs req_*/flag_* pass SYNC flops before use; all timings below are after sync.
//  IDLE: clr=1. Channel i is eligible when exactly one of req_wr[i]/req_rd[i] is set and done[i]=0.
//   Both set -> err, err_code=3; channel ignored until one drops.
//   Pick first eligible channel at/after rr pointer (round-robin) -> ARB.
//  ARB (1 cyc): latch window, op type, grant one-hot.
//   begin>end -> err, err_code=1, done[i]=1, op skipped -> RELEASE.
//   begin==end is a valid 1-word op.
//  SETUP (1 cyc): write -> clr=0; read -> clr stays 1.
//  START: assert start_wr or start_rd; zero timeout counter -> WAIT_HI.
//  WAIT_HI: wait for matching flag=1 -> WAIT_LO. start_* held high.
//  WAIT_LO: start_* deasserted on entry; wait for flag=0 -> CLOSE.
//   Counter counts in WAIT_HI+WAIT_LO; reaching TIMEOUT -> err, err_code=2,
//   start_*=0, clr=1, done[i]=1, bank unchanged -> RELEASE.
//  CLOSE (1 cyc): clr=1. Write -> toggle bank. done[i]=1.
//  RELEASE: grant=0, rr pointer=i+1 mod NCH -> IDLE.
//   done[i] clears the cycle after the synced req of channel i is low.
//  Latency: request sync edge -> start_* high = 3 clk (ARB, SETUP, START).
//  err_code holds first error only. err_clr clears err and err_code; a new error in the
//   same cycle wins over err_clr.
//  Request dropped mid-op: op runs to completion; done is set then cleared next cycle.
//  RST mid-op: immediate return to reset values; the core sees start_* fall.
//  addr_* hold last value outside an op.
// STRUCTURE
//  Shared package: state encoding localparams, ERR_* code constants.
//  Sub-module sdram_seq_sync (SYNC-deep bit synchroniser, width parameter) for req_*/flag_*.
//  Round-robin picker and FSM live in this file.
// TESTING
//  1 NCH=2, ch0 req_wr, window 0x0010..0x001F, core flag high 5 cyc -> start_wr 3 clk after sync;
//    clr=0 during op; done[0]=1; bank 0->1.
//  2 ch0 and ch1 both req_rd in same cycle, rr=0 -> ch0 served first, then ch1;
//    grant 01 then 10; bank unchanged.
//  3 ch1 write window begin=0x0020, end=0x001F -> no start_wr; err=1, err_code=1, done[1]=1.
//  4 TIMEOUT=32, flag_wr never rises -> err_code=2 at cycle 32 of wait; start_wr=0; clr=1; bank unchanged.
//  5 req_wr[0] and req_rd[0] both high -> err_code=3, no grant;
//    err_clr -> err=0; drop rd -> write proceeds.
//  6 RST asserted during WAIT_LO -> all outputs at reset values next edge;
//    after release, re-request completes normally.

Source files
------------

// File: rtl/sdram_burst_sequencer_pkg.sv
// Shared state encoding and error codes for the multi-channel SDRAM burst sequencer.
// Pure declarations: no latency or backpressure of its own.
package sdram_burst_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_CLOSE,
        S_RELEASE
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_WINDOW   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CONFLICT = 2'd3;

endpackage

// File: rtl/sdram_seq_sync.sv
// SYNC-deep bit synchroniser bank for asynchronous level inputs.
// Latency SYNC clk per bit; no flow control, every bit is sampled every cycle.
module sdram_seq_sync #(
    parameter int W    = 1,
    parameter int SYNC = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [SYNC];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < SYNC; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[SYNC-1];

endmodule

// File: rtl/sdram_burst_sequencer.sv
// Round-robin arbiter + burst FSM driving the SDRAM core start/flag handshake, ping-pong bank and FIFO clear.
// Latency: synced request -> start_* in 3 clk; core backpressure is the flag handshake, bounded by a TIMEOUT watchdog.
module sdram_burst_sequencer
    import sdram_burst_sequencer_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int NCH     = 2,
    parameter int TIMEOUT = 65535,
    parameter int SYNC    = 2
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [NCH-1:0]        req_wr,
    input  logic [NCH-1:0]        req_rd,
    input  logic [NCH*ADDR_W-1:0] wr_begin_in,
    input  logic [NCH*ADDR_W-1:0] wr_end_in,
    input  logic [NCH*ADDR_W-1:0] rd_begin_in,
    input  logic [NCH*ADDR_W-1:0] rd_end_in,
    input  logic                  flag_wr,
    input  logic                  flag_rd,
    input  logic                  err_clr,
    output logic                  start_wr,
    output logic                  start_rd,
    output logic [ADDR_W-1:0]     addr_begin,
    output logic [ADDR_W-1:0]     addr_end,
    output logic [NCH-1:0]        grant,
    output logic [NCH-1:0]        done,
    output logic                  bank,
    output logic                  clr,
    output logic                  err,
    output logic [1:0]            err_code
);

    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [NCH-1:0] wr_s, rd_s, both_q, eligible, finish_mask;
    logic           flag_wr_s, flag_rd_s, flag_s;
    logic           found, bad_win, tmo_exit, in_wait;
    logic [PW-1:0]  rr, cur, pick;
    logic           op_wr;
    logic [CW-1:0]  cnt;
    logic [1:0]     ev_code;
    state_t         state, state_nxt;

    sdram_seq_sync #(.W(2*NCH+2), .SYNC(SYNC)) u_sync (
        .clk (clk),
        .rst (RST),
        .d   ({req_wr, req_rd, flag_wr, flag_rd}),
        .q   ({wr_s, rd_s, flag_wr_s, flag_rd_s})
    );

    // A channel asking for both directions, or already done, is never eligible.
    always_comb begin
        eligible = (wr_s ^ rd_s) & ~done;
        found    = 1'b0;
        pick     = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!found && eligible[(int'(rr) + k) % NCH]) begin
                found = 1'b1;
                pick  = PW'((int'(rr) + k) % NCH);
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        flag_s      = op_wr ? flag_wr_s : flag_rd_s;
        bad_win     = addr_begin > addr_end;
        in_wait     = (state == S_WAIT_HI) || (state == S_WAIT_LO);
        tmo_exit    = (cnt == CNT_LAST) &&
                      (((state == S_WAIT_HI) && !flag_s) || ((state == S_WAIT_LO) && flag_s));
        start_wr    = op_wr  && ((state == S_START) || (state == S_WAIT_HI));
        start_rd    = !op_wr && ((state == S_START) || (state == S_WAIT_HI));
        clr         = !(op_wr && ((state == S_SETUP) || (state == S_START) || in_wait));
        finish_mask = '0;
        ev_code     = ERR_NONE;
        case (state)
            S_IDLE:    if (found) state_nxt = S_ARB;
            S_ARB:     state_nxt = bad_win ? S_RELEASE : S_SETUP;
            S_SETUP:   state_nxt = S_START;
            S_START:   state_nxt = S_WAIT_HI;
            S_WAIT_HI: if (flag_s) state_nxt = S_WAIT_LO;
                       else if (tmo_exit) state_nxt = S_RELEASE;
            S_WAIT_LO: if (!flag_s) state_nxt = S_CLOSE;
                       else if (tmo_exit) state_nxt = S_RELEASE;
            S_CLOSE:   state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if ((state == S_CLOSE) || ((state == S_ARB) && bad_win) || tmo_exit) finish_mask = grant;
        // Conflict fires once per rising both-set condition so err_clr can take effect.
        if (|(wr_s & rd_s & ~both_q)) ev_code = ERR_CONFLICT;
        if ((state == S_ARB) && bad_win) ev_code = ERR_WINDOW;
        if (tmo_exit) ev_code = ERR_TIMEOUT;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rr         <= '0;
            cur        <= '0;
            op_wr      <= 1'b0;
            grant      <= '0;
            addr_begin <= '0;
            addr_end   <= '0;
            cnt        <= '0;
            done       <= '0;
            bank       <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            both_q     <= '0;
        end else begin
            both_q <= wr_s & rd_s;
            done   <= (done & (wr_s | rd_s)) | finish_mask;
            if ((state == S_IDLE) && found) begin
                cur   <= pick;
                grant <= NCH'(1) << pick;
                op_wr <= wr_s[pick];
                if (wr_s[pick]) begin
                    addr_begin <= wr_begin_in[int'(pick)*ADDR_W +: ADDR_W];
                    addr_end   <= wr_end_in[int'(pick)*ADDR_W +: ADDR_W];
                end else begin
                    addr_begin <= rd_begin_in[int'(pick)*ADDR_W +: ADDR_W];
                    addr_end   <= rd_end_in[int'(pick)*ADDR_W +: ADDR_W];
                end
            end
            if (state == S_START) cnt <= '0;
            else if (in_wait)     cnt <= cnt + 1'b1;
            if ((state == S_CLOSE) && op_wr) bank <= ~bank;
            if (state == S_RELEASE) begin
                grant <= '0;
                rr    <= (cur == PW'(NCH - 1)) ? '0 : cur + 1'b1;
            end
            if (ev_code != ERR_NONE) begin
                err <= 1'b1;
                if (!err || err_clr) err_code <= ev_code;
            end else if (err_clr) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
        end
    end

endmodule

// File: tb/tb_sdram_burst_sequencer.sv
// Scoreboard bench: stimulus pushes expected ops, a monitor pops them on each done rise.
// A behavioural core model answers start_* with a flag pulse.
module tb_sdram_burst_sequencer;

    localparam int ADDR_W  = 16;
    localparam int NCH     = 2;
    localparam int TIMEOUT = 32;
    localparam int SYNC    = 2;

    logic                  clk = 1'b0;
    logic                  RST;
    logic [NCH-1:0]        req_wr, req_rd;
    logic [NCH*ADDR_W-1:0] wr_begin_in, wr_end_in, rd_begin_in, rd_end_in;
    logic                  flag_wr, flag_rd, err_clr;
    logic                  start_wr, start_rd, bank, clr, err;
    logic [ADDR_W-1:0]     addr_begin, addr_end;
    logic [NCH-1:0]        grant, done;
    logic [1:0]            err_code;

    sdram_burst_sequencer #(.ADDR_W(ADDR_W), .NCH(NCH), .TIMEOUT(TIMEOUT), .SYNC(SYNC)) dut (
        .clk(clk), .RST(RST), .req_wr(req_wr), .req_rd(req_rd),
        .wr_begin_in(wr_begin_in), .wr_end_in(wr_end_in),
        .rd_begin_in(rd_begin_in), .rd_end_in(rd_end_in),
        .flag_wr(flag_wr), .flag_rd(flag_rd), .err_clr(err_clr),
        .start_wr(start_wr), .start_rd(start_rd),
        .addr_begin(addr_begin), .addr_end(addr_end),
        .grant(grant), .done(done), .bank(bank), .clr(clr),
        .err(err), .err_code(err_code)
    );

    initial forever #5 clk = ~clk;

    // kind: 0 normal burst, 1 bad window (skipped), 2 core never answers (timeout)
    typedef struct {
        int ch;
        bit wr;
        int beg;
        int fin;
        int kind;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   m_bank, m_rr, m_ec;
    int   core_en = 1;
    int   hold_fix = 0;
    bit   r_wr [NCH];
    int   r_b  [NCH];
    int   r_e  [NCH];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_wr"}, start_wr, 0);
        check({tag, "_start_rd"}, start_rd, 0);
        check({tag, "_addr_begin"}, addr_begin, 0);
        check({tag, "_addr_end"}, addr_end, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_bank"}, bank, 0);
        check({tag, "_clr"}, clr, 1);
        check({tag, "_err"}, err, 0);
        check({tag, "_err_code"}, err_code, 0);
    endtask

    // Behavioural SDRAM core: after a short delay raise the matching flag for a few cycles.
    initial begin : core
        int cph, ccnt;
        bit cwr;
        flag_wr = 1'b0;
        flag_rd = 1'b0;
        cph = 0;
        ccnt = 0;
        cwr = 1'b0;
        forever begin
            @(negedge clk);
            if (RST) begin
                cph = 0;
                flag_wr = 1'b0;
                flag_rd = 1'b0;
            end else begin
                case (cph)
                    0: if (core_en != 0 && (start_wr || start_rd)) begin
                        cwr = start_wr;
                        ccnt = $urandom_range(0, 2);
                        cph = 1;
                    end
                    1: if (ccnt == 0) begin
                        if (cwr) flag_wr = 1'b1;
                        else     flag_rd = 1'b1;
                        ccnt = (hold_fix != 0) ? hold_fix : $urandom_range(1, 5);
                        cph = 2;
                    end else ccnt--;
                    2: begin
                        ccnt--;
                        if (ccnt == 0) begin
                            flag_wr = 1'b0;
                            flag_rd = 1'b0;
                            cph = 3;
                        end
                    end
                    default: if (!start_wr && !start_rd) cph = 0;
                endcase
            end
        end
    end

    initial begin : monitor
        logic [NCH-1:0] prev_done;
        bit   saw_wr, saw_rd, saw_clr_lo, prev_start;
        int   start_cyc;
        exp_t e;
        prev_done = '0;
        saw_wr = 0; saw_rd = 0; saw_clr_lo = 0; prev_start = 0;
        start_cyc = 0;
        forever begin
            @(negedge clk);
            if (RST) begin
                prev_done = '0;
                saw_wr = 0; saw_rd = 0; saw_clr_lo = 0; prev_start = 0;
            end else begin
                if ((start_wr || start_rd) && !prev_start) start_cyc = cyc;
                prev_start = start_wr || start_rd;
                if (start_wr) saw_wr = 1;
                if (start_rd) saw_rd = 1;
                if (!clr) saw_clr_lo = 1;
                for (int c = 0; c < NCH; c++) begin
                    if (done[c] && !prev_done[c]) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_done: done rose on ch %0d, expected no completion", c);
                        end else begin
                            e = exp_q.pop_front();
                            check("done_channel", c, e.ch);
                            check("grant", grant, 1 << e.ch);
                            check("addr_begin", addr_begin, e.beg);
                            check("addr_end", addr_end, e.fin);
                            if (e.kind == 0) begin
                                check("start_wr_seen", saw_wr, e.wr);
                                check("start_rd_seen", saw_rd, !e.wr);
                                check("clr_low_seen", saw_clr_lo, e.wr);
                                if (e.wr) m_bank ^= 1;
                            end else if (e.kind == 1) begin
                                check("bad_window_no_start", saw_wr | saw_rd, 0);
                                if (m_ec == 0) m_ec = 1;
                            end else begin
                                check("tmo_start_seen", saw_wr, e.wr);
                                check("tmo_cycles", cyc - start_cyc, TIMEOUT + 1);
                                check("tmo_start_low", start_wr | start_rd, 0);
                                check("tmo_clr_high", clr, 1);
                                if (m_ec == 0) m_ec = 2;
                            end
                            check("bank", bank, m_bank);
                            check("err", err, (m_ec != 0));
                            check("err_code", err_code, m_ec);
                        end
                        saw_wr = 0; saw_rd = 0; saw_clr_lo = 0;
                    end
                end
                prev_done = done;
            end
        end
    end

    task automatic err_clear();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_ec = 0;
        @(negedge clk);
        check("err_after_clr", err, 0);
        check("err_code_after_clr", err_code, 0);
    endtask

    task automatic set_window(input int c);
        if (r_wr[c]) begin
            wr_begin_in[c*ADDR_W +: ADDR_W] = ADDR_W'(r_b[c]);
            wr_end_in[c*ADDR_W +: ADDR_W]   = ADDR_W'(r_e[c]);
        end else begin
            rd_begin_in[c*ADDR_W +: ADDR_W] = ADDR_W'(r_b[c]);
            rd_end_in[c*ADDR_W +: ADDR_W]   = ADDR_W'(r_e[c]);
        end
    endtask

    // All channels in mask raise together; service order is round-robin from m_rr.
    task automatic run_round(input logic [NCH-1:0] mask, input int kind_ok, input bit chk_lat);
        exp_t e;
        int   last, n, c;
        last = 0;
        for (int k = 0; k < NCH; k++) begin
            c = (m_rr + k) % NCH;
            if (mask[c]) begin
                e.ch   = c;
                e.wr   = r_wr[c];
                e.beg  = r_b[c];
                e.fin  = r_e[c];
                e.kind = (r_b[c] > r_e[c]) ? 1 : kind_ok;
                exp_q.push_back(e);
                last = c;
            end
        end
        m_rr = (last + 1) % NCH;
        for (int i = 0; i < NCH; i++) begin
            if (mask[i]) begin
                set_window(i);
                req_wr[i] = r_wr[i];
                req_rd[i] = !r_wr[i];
            end
        end
        if (chk_lat) begin
            n = 0;
            while (!(start_wr || start_rd) && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("start_latency", n, SYNC + 3);
        end
        n = 0;
        while ((done & mask) != mask && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("round_all_done", done & mask, mask);
        req_wr = req_wr & ~mask;
        req_rd = req_rd & ~mask;
        n = 0;
        while ((done & mask) != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("done_cleared", done & mask, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : stim
        int n, any_g;
        exp_t e;
        RST = 1'b1;
        req_wr = '0; req_rd = '0; err_clr = 1'b0;
        wr_begin_in = '0; wr_end_in = '0; rd_begin_in = '0; rd_end_in = '0;
        m_bank = 0; m_rr = 0; m_ec = 0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        RST = 1'b0;
        repeat (2) @(negedge clk);

        // Both channels read at once from rr=0: ch0 then ch1, bank untouched.
        r_wr[0] = 0; r_b[0] = 'h0100; r_e[0] = 'h01FF;
        r_wr[1] = 0; r_b[1] = 'h0200; r_e[1] = 'h0200;
        run_round(2'b11, 0, 0);

        // ch0 write 0x10..0x1F with a 5-cycle busy flag; start 3 clk after sync, bank flips.
        hold_fix = 5;
        r_wr[0] = 1; r_b[0] = 'h0010; r_e[0] = 'h001F;
        run_round(2'b01, 0, 1);
        hold_fix = 0;

        // ch1 inverted write window is skipped with a window error.
        r_wr[1] = 1; r_b[1] = 'h0020; r_e[1] = 'h001F;
        run_round(2'b10, 0, 0);

        // Core never answers: timeout error, bank unchanged.
        err_clear();
        core_en = 0;
        r_wr[0] = 1; r_b[0] = 'h0300; r_e[0] = 'h03FF;
        run_round(2'b01, 2, 0);
        core_en = 1;

        // Conflicting wr+rd on ch0: error 3, no grant; clear, then drop rd and let the write run.
        err_clear();
        r_wr[0] = 1; r_b[0] = 'h0400; r_e[0] = 'h0401;
        set_window(0);
        req_wr[0] = 1'b1;
        req_rd[0] = 1'b1;
        any_g = 0;
        repeat (8) begin
            @(negedge clk);
            if (grant != 0) any_g = 1;
        end
        check("conflict_err", err, 1);
        check("conflict_err_code", err_code, 3);
        check("conflict_no_grant", any_g, 0);
        m_ec = 3;
        err_clear();
        e.ch = 0; e.wr = 1; e.beg = 'h0400; e.fin = 'h0401; e.kind = 0;
        exp_q.push_back(e);
        m_rr = 1;
        req_rd[0] = 1'b0;
        n = 0;
        while (!done[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("conflict_resolved_done", done[0], 1);
        req_wr[0] = 1'b0;
        repeat (6) @(negedge clk);

        for (int r = 0; r < 40; r++) begin
            logic [NCH-1:0] mask;
            int sel;
            mask = NCH'($urandom_range(1, (1 << NCH) - 1));
            for (int c = 0; c < NCH; c++) begin
                r_wr[c] = 1'($urandom_range(0, 1));
                sel = $urandom_range(0, 7);
                if (sel == 0) begin
                    r_b[c] = $urandom_range(1, 65535);
                    r_e[c] = $urandom_range(0, r_b[c] - 1);
                end else if (sel == 1) begin
                    r_b[c] = $urandom_range(0, 65535);
                    r_e[c] = r_b[c];
                end else begin
                    r_b[c] = $urandom_range(0, 65535);
                    r_e[c] = $urandom_range(r_b[c], 65535);
                end
            end
            run_round(mask, 0, 0);
        end

        // Reset in the middle of WAIT_LO, then a fresh request completes.
        hold_fix = 5;
        r_wr[0] = 1; r_b[0] = 'h0500; r_e[0] = 'h05FF;
        set_window(0);
        req_wr[0] = 1'b1;
        n = 0;
        while (!start_wr && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (start_wr && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait_lo", start_wr, 0);
        RST = 1'b1;
        req_wr = '0;
        @(negedge clk);
        check_reset_outputs("midop_reset");
        exp_q.delete();
        m_bank = 0; m_rr = 0; m_ec = 0;
        @(negedge clk);
        RST = 1'b0;
        repeat (3) @(negedge clk);
        hold_fix = 0;
        r_wr[0] = 1; r_b[0] = 'h0600; r_e[0] = 'h0610;
        run_round(2'b01, 0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
